// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
// Round-robin, packet-locked arbiter sharing the single write port of a sync
// FIFO between N_REQ streaming requesters. A requester keeps the grant for a
// whole packet; new packets only start while the FIFO reports headroom
// (prog_full low), and a watchdog aborts packets whose owner stops sending.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | no packet locked; pick next valid requester if prog_full is low
//   ST_XFER | packet locked to o_grant_id; beats pass through to the FIFO
module fifo_write_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [N_REQ-1:0]              i_req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   i_req_data,
  input  logic [N_REQ-1:0]              i_req_last,
  output logic [N_REQ-1:0]              o_req_ready,
  output logic                          o_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         o_fifo_data,
  input  logic                          i_fifo_full,
  input  logic                          i_fifo_prog_full,
  output logic                          o_grant_valid,
  output logic [$clog2(N_REQ)-1:0]      o_grant_id,
  output logic                          o_timeout,
  output logic [15:0]                   o_pkt_count
);

  localparam int IW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t          r_state;
  logic            r_grant_valid;
  logic [IW-1:0]   r_grant_id;
  logic [IW-1:0]   r_last_id;
  logic [WW-1:0]   r_wdog;
  logic            r_timeout;
  logic [15:0]     r_pkt_count;

  logic            w_sel_found;
  logic [IW-1:0]   w_sel_id;
  logic [IW:0]     w_idx;
  logic            w_xfer;
  logic            w_valid_g;
  logic            w_last_g;
  logic            w_accept;
  logic            w_wdog_expired;

  // Round-robin search starting just after the last served requester.
  // Offsets are walked from farthest to nearest so the nearest valid wins.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_id    = '0;
    w_idx       = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      w_idx = {1'b0, r_last_id} + (IW+1)'(i);
      if (w_idx >= (IW+1)'(N_REQ)) begin
        w_idx = w_idx - (IW+1)'(N_REQ);
      end
      if (i_req_valid[w_idx[IW-1:0]]) begin
        w_sel_found = 1'b1;
        w_sel_id    = w_idx[IW-1:0];
      end
    end
  end

  assign w_xfer         = (r_state == ST_XFER);
  assign w_valid_g      = i_req_valid[r_grant_id];
  assign w_last_g       = i_req_last[r_grant_id];
  assign w_accept       = w_xfer & w_valid_g & ~i_fifo_full;
  assign w_wdog_expired = (r_wdog == WW'(TIMEOUT - 1));

  // Ready goes only to the locked requester; only FIFO full stalls it.
  always_comb begin
    o_req_ready = '0;
    if (w_xfer && !i_fifo_full) begin
      o_req_ready[r_grant_id] = 1'b1;
    end
  end

  // Write data always follows the granted slice, qualified by wr_en.
  always_comb begin
    o_fifo_data = i_req_data[0 +: DATA_WIDTH];
    for (int k = 0; k < N_REQ; k++) begin
      if (r_grant_id == IW'(k)) begin
        o_fifo_data = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign o_fifo_wr_en  = w_accept;
  assign o_grant_valid = r_grant_valid;
  assign o_grant_id    = r_grant_id;
  assign o_timeout     = r_timeout;
  assign o_pkt_count   = r_pkt_count;

  // Arbitration FSM with packet lock, completion counting and watchdog abort.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_IDLE;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_last_id     <= IW'(N_REQ - 1);
      r_wdog        <= '0;
      r_timeout     <= 1'b0;
      r_pkt_count   <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_wdog <= '0;
          if (w_sel_found && !i_fifo_prog_full) begin
            r_grant_id    <= w_sel_id;
            r_grant_valid <= 1'b1;
            r_state       <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (w_accept) begin
            r_wdog <= '0;
            if (w_last_g) begin
              r_last_id     <= r_grant_id;
              r_pkt_count   <= r_pkt_count + 16'd1;
              r_grant_valid <= 1'b0;
              r_state       <= ST_IDLE;
            end
          end else if (w_valid_g) begin
            // Owner is presenting data but the FIFO is full: not its fault.
            r_wdog <= '0;
          end else if (w_wdog_expired) begin
            // Truncate the packet; beats already written stay in the FIFO.
            r_timeout     <= 1'b1;
            r_last_id     <= r_grant_id;
            r_grant_valid <= 1'b0;
            r_wdog        <= '0;
            r_state       <= ST_IDLE;
          end else begin
            r_wdog <= r_wdog + WW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares the single write port of a sync FIFO instance (wr_en/din/full/prog_full) between N_REQ streaming requesters.
- Sits between the requester datapaths and the FIFO.
- Grants one requester at a time for a whole packet (until its last beat).
- Starts new packets only when the FIFO has headroom, and aborts stalled packets via a watchdog.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, beat width; must equal the FIFO write width.
- TIMEOUT, 256, cycles a granted requester may hold valid low mid-packet before abort (>=2).

Ports:
- i_clk  in  1  single clock for the block and the FIFO write side.
- i_reset_n  in  1  reset, asynchronous assert, active-low.
- i_req_valid  in  N_REQ  per-requester beat valid.
- i_req_data  in  N_REQ*DATA_WIDTH  per-requester beat data; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_req_last  in  N_REQ  per-requester last beat of packet.
- o_req_ready  out  N_REQ  per-requester beat accepted when valid&ready.
- o_fifo_wr_en  out  1  FIFO write enable.
- o_fifo_data  out  DATA_WIDTH  FIFO write data.
- i_fifo_full  in  1  FIFO full.
- i_fifo_prog_full  in  1  FIFO programmable-full; gates packet start.
- o_grant_valid  out  1  a packet is locked.
- o_grant_id  out  $clog2(N_REQ)  locked requester index.
- o_timeout  out  1  one-cycle pulse on watchdog abort.
- o_pkt_count  out  16  packets completed (wraps at 2^16).

Behaviour:
- Interface is decided: one clock; reset is asynchronous and active-low (i_clk, i_reset_n).
- Reset values:
  - o_grant_valid=0, o_grant_id=0, o_timeout=0, o_pkt_count=0.
  - Round-robin pointer last_id=N_REQ-1, so requester 0 has first priority.
  - Watchdog counter=0, state=IDLE.
  - Combinational outputs (o_req_ready, o_fifo_wr_en) are 0 while in reset.
- State IDLE:
  - o_req_ready=0, o_fifo_wr_en=0.
  - If any i_req_valid and !i_fifo_prog_full: select the first valid index searching last_id+1, last_id+2, ... modulo N_REQ.
  - Register it into o_grant_id, set o_grant_valid=1, go to XFER.
  - Arbitration latency is exactly 1 cycle; the first beat can transfer in the cycle after selection.
  - If prog_full=1, stay in IDLE regardless of requests.
- State XFER (g=o_grant_id):
  - o_req_ready[g] = !i_fifo_full; all other ready bits are 0.
  - o_fifo_wr_en = i_req_valid[g] & !i_fifo_full (combinational); o_fifo_data = data slice g.
  - o_fifo_data is don't-care when wr_en=0, but is driven from slice g.
  - prog_full is ignored mid-packet; only full stalls.
  - On a beat with i_req_last[g]=1: last_id<=g, o_pkt_count++, o_grant_valid<=0, go to IDLE. Back-to-back packets therefore have a minimum 1 idle cycle between them.
- Watchdog (XFER only):
  - Counter clears on every accepted beat and whenever i_req_valid[g]=1.
  - It increments while i_req_valid[g]=0.
  - Stalls caused by i_fifo_full do not count when valid is high.
  - When the counter reaches TIMEOUT-1 and valid is still low: pulse o_timeout for 1 cycle, set last_id<=g, return to IDLE, clear the counter.
  - o_pkt_count is not incremented on abort.
  - Beats already written stay in the FIFO; downstream detects the truncated packet.
- Simultaneous events:
  - A last beat with full=1 is not accepted; the block holds in XFER.
  - If timeout and accept would fall in the same cycle, accept wins (impossible by construction, since valid must be low to time out).
- Requester rules:
  - A requester must hold data/last stable while valid&!ready.
  - Dropping valid mid-packet is legal (it feeds the watchdog).
- Reset mid-packet: immediate return to the reset values; a partial packet may remain in the FIFO (the FIFO shares the same reset).
- The block never asserts o_fifo_wr_en while i_fifo_full=1, so the FIFO overflow flag must never fire.

Test Plan:
1. Reset then all 4 requesters valid with 3-beat packets, prog_full=0 -> grants in order 0,1,2,3,0. Each packet has 3 contiguous wr_en cycles, with 1 idle cycle between packets. o_pkt_count=4 after four packets.
2. Only requester 2 valid, i_fifo_prog_full=1 for 10 cycles then 0 -> no grant during those 10 cycles. Grant id=2 on the cycle after prog_full falls; first wr_en on the next cycle.
3. Requester 1 mid-packet, i_fifo_full=1 for 5 cycles with valid high -> o_req_ready[1]=0 and wr_en=0 for 5 cycles. No timeout. Data beat is written once full drops.
4. Requester 3 granted, sends 1 beat then drops valid, TIMEOUT=8 -> o_timeout pulses exactly 8 cycles after the last accepted beat. State returns to IDLE, o_pkt_count unchanged, next grant goes to requester 0 if valid.
5. Assert i_reset_n=0 asynchronously during beat 2 of a 4-beat packet -> outputs go to reset values without waiting for a clock edge. After release, requester 0 wins even if requester 1 was granted before reset.
6. Random valid/last/full traffic for 10k cycles with a scoreboard -> no overflow is ever seen at the FIFO. Per-requester beat order is preserved, and packets are never interleaved in the FIFO.
